gf_serial_mul: RTL and testbench

GF_SERIAL_MUL -- requirements
Module: gf_serial_mul

---
 rtl/gf_serial_mul.sv | 82 ++++++++
 tb/tb_gf_serial_mul.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf_serial_mul.sv
// rtl/gf_serial_mul.sv - bit-serial GF(2^M) multiplier, MSB-first Horner, one multiplier bit per cycle
module gf_serial_mul #(
    parameter int         M    = 8,
    parameter logic [M:0] POLY = 9'h11D
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_a,
    input  logic [M-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_p,
    output logic         busy
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [M-1:0]    a_reg;
    logic [M-1:0]    b_reg;
    logic [M-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic [M-1:0]    acc_xt;
    logic [M-1:0]    acc_next;

    // Multiply-by-x with reduction, then conditionally add the multiplicand.
    always_comb begin
        acc_xt   = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY[M-1:0] : '0);
        acc_next = acc_xt ^ (b_reg[cnt] ? a_reg : '0);
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        acc   <= '0;
                        cnt   <= CW'(M - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        out_p <= acc_next;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_serial_mul.sv
// tb/tb_gf_serial_mul.sv - randomized self-checking bench for gf_serial_mul against a polynomial-arithmetic model
module tb_gf_serial_mul;

    localparam int M = 8;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_a;
    logic [M-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_p;
    logic         busy;

    logic         in_valid2;
    logic         in_ready2;
    logic [M-1:0] in_a2;
    logic [M-1:0] in_b2;
    logic         out_valid2;
    logic         out_ready2;
    logic [M-1:0] out_p2;
    logic         busy2;

    int checks;
    int failures;

    gf_serial_mul #(.M(8), .POLY(9'h11D)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
    );

    gf_serial_mul #(.M(8), .POLY(9'h11B)) dut_aes (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_p(out_p2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry-less product followed by polynomial long division.
    function automatic logic [15:0] gf_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic [16:0] poly, input int m);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < m; i++)
            if (b[i]) p = p ^ (32'(a) << i);
        for (int i = 2 * m - 2; i >= m; i--)
            if (p[i]) p = p ^ (32'(poly) << (i - m));
        return p[15:0];
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                          input bit corrupt, input string name);
        int t;
        logic [15:0] full;
        logic [7:0]  expv;
        logic [7:0]  held;
        full = gf_ref(16'(a), 16'(b), 17'h11D, M);
        expv = full[7:0];
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_timeout in_ready=%b required=1", name, in_ready);
        end
        in_a = a; in_b = b; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s accept busy=%b in_ready=%b required busy=1 in_ready=0", name, busy, in_ready);
        end
        t = 0;
        while (out_valid !== 1'b1 && t < 40) begin
            if (corrupt) begin
                in_a = M'($urandom); in_b = M'($urandom); in_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        checks++;
        if (t != M) begin
            failures++;
            $display("FAIL %s latency got=%0d required=%0d", name, t, M);
        end
        checks++;
        if (out_p !== expv) begin
            failures++;
            $display("FAIL %s product a=%h b=%h got=%h required=%h", name, a, b, out_p, expv);
        end
        held = out_p;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_p !== held) begin
                failures++;
                $display("FAIL %s stall%0d out_valid=%b out_p=%h required 1/%h", name, s, out_valid, out_p, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s release in_ready=%b out_valid=%b busy=%b required 1/0/0", name, in_ready, out_valid, busy);
        end
        checks++;
        if (out_p !== expv) begin
            failures++;
            $display("FAIL %s hold_after got=%h required=%h", name, out_p, expv);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; out_ready2 = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_p !== 8'h00) begin
            failures++;
            $display("FAIL reset_state in_ready=%b out_valid=%b busy=%b out_p=%h required 1/0/0/00",
                     in_ready, out_valid, busy, out_p);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(8'h02, 8'h80, 0, 1'b0, "basic_02x80");
        run_op(8'h01, 8'hB7, 0, 1'b0, "ident_01xB7");
        run_op(8'hFF, 8'h01, 0, 1'b0, "ident_FFx01");
        run_op(8'h00, 8'hA5, 0, 1'b0, "zero_00xA5");
        run_op(8'hFF, 8'hFF, 0, 1'b0, "max_FFxFF");
    endtask

    task automatic test_backpressure();
        run_op(8'h57, 8'h83, 5, 1'b0, "stall5");
    endtask

    task automatic test_corruption();
        for (int i = 0; i < 4; i++)
            run_op(8'($urandom), 8'($urandom), 1, 1'b1, "corrupt");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "random");
    endtask

    task automatic test_poly_override();
        int t;
        logic [15:0] full;
        full = gf_ref(16'h0053, 16'h00CA, 17'h11B, M);
        in_a2 = 8'h53; in_b2 = 8'hCA; in_valid2 = 1'b1; out_ready2 = 1'b0;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        t = 0;
        while (out_valid2 !== 1'b1 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (out_p2 !== 8'h01 || t != M) begin
            failures++;
            $display("FAIL poly11B_53xCA got=%h latency=%0d required=01 latency=%0d", out_p2, t, M);
        end
        checks++;
        if (out_p2 !== full[7:0]) begin
            failures++;
            $display("FAIL poly11B_model got=%h required=%h", out_p2, full[7:0]);
        end
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        in_a = 8'h37; in_b = 8'h59; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_p !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_op in_ready=%b out_valid=%b busy=%b out_p=%h required 1/0/0/00",
                     in_ready, out_valid, busy, out_p);
        end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold out_valid=%b required=0", out_valid);
            end
        end
        reset_n = 1'b1;
        out_ready = 1'b0;
        run_op(8'h02, 8'h80, 0, 1'b0, "after_reset_02x80");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            run_op(8'($urandom), 8'($urandom), 0, 1'b0, "back_to_back");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_corruption();
        test_poly_override();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
